// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one byte at a time from N_REQ requesters to a UART transmitter.
// Each frame is tracked through its start bit and its done edge, and is aborted if it never starts.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   sent,
  output logic               err,
  output logic               busy,
  output logic [2:0]         grant_id,
  output logic               data_update,
  output logic [7:0]         din_tx,
  input  logic               tx_line,
  input  logic               done_tx
);

  localparam int              CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [2:0]       LAST_RST = 3'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         last_q, last_d;
  logic [2:0]         grant_q, grant_d;
  logic [7:0]         din_q, din_d;
  logic               dup_q, dup_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   sent_q, sent_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q;

  logic               sel_found;
  logic [2:0]         sel_idx;
  logic [7:0]         sel_byte;

  // Search starts one past the last grant, so a held request cannot starve the others.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_byte  = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!sel_found && req[i] && (((int'(last_q) + off) % N_REQ) == i)) begin
          sel_found = 1'b1;
          sel_idx   = 3'(i);
          sel_byte  = req_data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    din_d   = din_q;
    dup_d   = dup_q;
    ack_d   = '0;
    sent_d  = '0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          din_d   = sel_byte;
          grant_d = sel_idx;
          last_d  = sel_idx;
          ack_d   = ONE << sel_idx;
          dup_d   = 1'b1;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        // A start bit seen on the final timeout cycle still counts as a start.
        if (!tx_line) begin
          dup_d   = 1'b0;
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          dup_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        // Only a fresh rising edge of done_tx completes the frame.
        if (done_tx && !done_q) begin
          sent_d  = ONE << grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      grant_q <= '0;
      din_q   <= '0;
      dup_q   <= 1'b0;
      ack_q   <= '0;
      sent_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      din_q   <= din_d;
      dup_q   <= dup_d;
      ack_q   <= ack_d;
      sent_q  <= sent_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      done_q  <= done_tx;
    end
  end

  assign ack         = ack_q;
  assign sent        = sent_q;
  assign err         = err_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_q;
  assign data_update = dup_q;
  assign din_tx      = din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 2-clk-per-bit transmitter model and a line decoder.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack, sent;
  logic           err, busy, data_update;
  logic [2:0]     grant_id;
  logic [7:0]     din_tx;
  logic           tx_line, done_tx;

  logic xm_en, xm_line, xm_done, xm_busy;
  logic man_line, man_done;

  int n_chk  = 0;
  int n_pass = 0;
  int ack_cnt = 0, sent_cnt = 0, err_cnt = 0;
  logic [7:0] dec[$];

  assign tx_line = xm_en ? xm_line : man_line;
  assign done_tx = xm_en ? xm_done : man_done;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .sent(sent), .err(err), .busy(busy), .grant_id(grant_id),
    .data_update(data_update), .din_tx(din_tx), .tx_line(tx_line), .done_tx(done_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_ack(output logic [N-1:0] a);
    a = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ack != '0) begin a = ack; break; end
    end
  endtask

  task automatic wait_sent(output logic [N-1:0] s);
    s = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sent != '0) begin s = sent; break; end
    end
  endtask

  always @(negedge clk) begin
    ack_cnt  = ack_cnt + $countones(ack);
    sent_cnt = sent_cnt + $countones(sent);
    err_cnt  = err_cnt + int'(err);
  end

  // Transmitter model: start, 8 data bits LSB first, stop, then a 2-clk done level.
  initial begin
    logic [7:0] sh;
    xm_line = 1'b1; xm_done = 1'b0; xm_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (xm_en && data_update) begin
        xm_busy = 1'b1;
        sh = din_tx;
        @(posedge clk); #1 xm_line = 1'b0;
        repeat (2) @(posedge clk);
        for (int j = 0; j < 8; j++) begin
          #1 xm_line = sh[j];
          repeat (2) @(posedge clk);
        end
        #1 xm_line = 1'b1;
        repeat (2) @(posedge clk);
        #1 xm_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 xm_done = 1'b0;
        xm_busy = 1'b0;
      end
    end
  end

  // Line decoder sampling mid-bit on falling clock edges.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_line === 1'b0) begin
        b = '0;
        repeat (2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          b[j] = tx_line;
          repeat (2) @(negedge clk);
        end
        dec.push_back(b);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] a, s;
    int base, n, ok;

    rst_n = 1'b0; req = '0; req_data = '0;
    xm_en = 1'b1; man_line = 1'b1; man_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_dup", data_update, 0);
    chk("rst_din", din_tx, 8'h00);
    chk("rst_gid", grant_id, 0);
    chk("rst_pulses", {ack, sent, err}, 0);

    // Two requesters, minimum latency, frame decode
    rst_n = 1'b1;
    req_data = {8'h00, 8'h3C, 8'h00, 8'hA5};
    @(posedge clk); #1 req = 4'b0101;
    @(posedge clk); @(negedge clk);
    chk("lat_dup", data_update, 1);
    chk("first_ack", ack, 4'b0001);
    chk("first_din", din_tx, 8'hA5);
    chk("first_busy", busy, 1);
    req = 4'b0100;
    wait_sent(s);
    chk("first_sent", s, 4'b0001);
    wait_ack(a);
    chk("second_ack", a, 4'b0100);
    chk("second_din", din_tx, 8'h3C);
    chk("second_gid", grant_id, 2);
    req = '0;
    wait_sent(s);
    chk("second_sent", s, 4'b0100);
    repeat (3) @(negedge clk);
    chk("idle_gid_hold", grant_id, 2);
    chk("idle_busy", busy, 0);
    chk("dec_count", dec.size(), 2);
    chk("dec_0", (dec.size() > 0) ? dec[0] : 32'hDEAD, 8'hA5);
    chk("dec_1", (dec.size() > 1) ? dec[1] : 32'hDEAD, 8'h3C);

    // All four requesting for eight frames
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    ack_cnt = 0; sent_cnt = 0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      wait_ack(a);
      if (f == 7) req = '0;
      chk($sformatf("rr_ack%0d", f), a, 4'b0001 << (f % 4));
      wait_sent(s);
      chk($sformatf("rr_sent%0d", f), s, 4'b0001 << (f % 4));
    end
    repeat (2) @(negedge clk);
    chk("rr_ack_cnt", ack_cnt, 8);
    chk("rr_sent_cnt", sent_cnt, 8);

    // Start timeout with the line held idle
    xm_en = 1'b0; man_line = 1'b1; man_done = 1'b0;
    base = sent_cnt; n = err_cnt;
    @(posedge clk); #1 req = 4'b0010;
    wait_ack(a);
    req = '0;
    chk("to_ack", a, 4'b0010);
    ok = 0;
    while (data_update && ok < 100) begin
      ok++;
      @(negedge clk);
    end
    chk("to_dup_len", ok, 16);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    @(negedge clk);
    chk("to_err_pulse", err, 0);
    chk("to_err_cnt", err_cnt - n, 1);
    chk("to_no_sent", sent_cnt - base, 0);

    // done_tx already high before the start bit
    man_done = 1'b1;
    base = sent_cnt;
    @(posedge clk); #1 req = 4'b0001;
    wait_ack(a);
    req = '0;
    chk("dh_ack", a, 4'b0001);
    @(posedge clk); #1 man_line = 1'b0;
    repeat (2) @(posedge clk); #1 man_line = 1'b1;
    repeat (5) @(negedge clk);
    chk("dh_dup", data_update, 0);
    chk("dh_busy", busy, 1);
    chk("dh_no_sent", sent_cnt - base, 0);
    @(posedge clk); #1 man_done = 1'b0;
    @(posedge clk); #1 man_done = 1'b1;
    wait_sent(s);
    chk("dh_sent", s, 4'b0001);
    man_done = 1'b0;
    repeat (30) @(negedge clk);

    // Captured byte survives req_data changes
    xm_en = 1'b1;
    dec.delete();
    req_data = {8'hFF, 8'h00, 8'h00, 8'h00};
    @(posedge clk); #1 req = 4'b1000;
    wait_ack(a);
    chk("hold_ack", a, 4'b1000);
    chk("hold_din0", din_tx, 8'hFF);
    req = '0; req_data = '0;
    ok = 1; s = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sent != '0) begin s = sent; break; end
      if (din_tx !== 8'hFF) ok = 0;
    end
    chk("hold_din", ok, 1);
    chk("hold_sent", s, 4'b1000);
    chk("hold_dec", (dec.size() > 0) ? dec[0] : 32'hDEAD, 8'hFF);

    // Reset during WAIT_DONE
    req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
    @(posedge clk); #1 req = 4'b0100;
    wait_ack(a);
    req = '0;
    chk("mr_ack", a, 4'b0100);
    ok = 0;
    for (int k = 0; k < 50 && (data_update || !busy); k++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("mr_in_wait", {busy, data_update}, 2'b10);
    base = sent_cnt; n = err_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_dup", data_update, 0);
    chk("mr_din", din_tx, 8'h00);
    chk("mr_gid", grant_id, 0);
    for (int k = 0; k < 100 && xm_busy; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("mr_no_pulse", {sent_cnt - base, err_cnt - n}, 0);
    rst_n = 1'b1;
    req_data = {8'h99, 8'h00, 8'h00, 8'h66};
    @(posedge clk); #1 req = 4'b1001;
    wait_ack(a);
    req = '0;
    chk("mr_next_ack", a, 4'b0001);
    chk("mr_next_din", din_tx, 8'h66);
    wait_sent(s);
    chk("mr_next_sent", s, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 4096: clk cycles allowed for the transmitter to start a frame before the controller aborts.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N_REQ  per-requester level request; bit i high means byte on req_data slice i is pending.
REQ-006 req_data  input  8*N_REQ  requester bytes; requester i occupies bits [8i+7:8i].
REQ-007 ack  output  N_REQ  one-hot, one-clk pulse; the byte of requester i has been captured.
REQ-008 sent  output  N_REQ  one-hot, one-clk pulse; the frame of requester i has completed.
REQ-009 err  output  1  one-clk pulse; a start timeout occurred.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 grant_id  output  3  index of the current or last granted requester.
REQ-012 data_update  output  1  start request to the transmitter; held high until a start bit is observed.
REQ-013 din_tx  output  8  byte presented to the transmitter; stable while data_update is high.
REQ-014 tx_line  input  1  monitored serial line from the transmitter.
REQ-015 done_tx  input  1  transmitter frame-done level from the transmitter.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, START, WAIT_DONE.
REQ-017 IDLE, any req bit high: select the first requester with req high, searching upward from (last_grant+1) mod N_REQ and wrapping.
REQ-018 IDLE, grant cycle, at the next edge: din_tx = selected req_data slice; grant_id = selected index; last_grant = selected index; ack[selected] = 1 for one cycle; data_update = 1; state = START.
REQ-019 IDLE, no req bit high: no outputs change except the pulse outputs clearing to 0.
REQ-020 START, tx_line sampled 0: data_update = 0 at the next edge; state = WAIT_DONE.
REQ-021 START: a timeout counter SHALL clear on entry and increment each cycle.
REQ-022 START, counter reaching TIMEOUT_CYC-1 with tx_line still 1: data_update = 0; err = 1 for one cycle; state = IDLE; no sent pulse.
REQ-023 If a start bit and the timeout occur in the same cycle, the start bit SHALL win.
REQ-024 WAIT_DONE: done_tx SHALL be registered every cycle into done_q, including outside WAIT_DONE.
REQ-025 WAIT_DONE, rising edge (done_tx=1, done_q=0): sent[grant_id] = 1 for one cycle; state = IDLE.
REQ-026 A done_tx level already high on entry to WAIT_DONE SHALL NOT complete the frame; a fresh rising edge is required.
REQ-027 Minimum latency is 1 clk from req high in IDLE to data_update high.
REQ-028 Back-to-back frames: the cycle after a sent pulse, IDLE SHALL arbitrate again.
REQ-029 req changes while busy SHALL have no effect on the frame in flight; the captured din_tx is not altered.
REQ-030 A requester SHALL deassert req after its ack; if req is held high, the requester is re-served in round-robin order.
REQ-031 A single continuously requesting requester SHALL be granted on every arbitration.
REQ-032 grant_id SHALL hold its value in IDLE.

Reset
REQ-033 rst_n low SHALL immediately force: state IDLE; data_update 0; din_tx 0x00; ack 0; sent 0; err 0; busy 0; grant_id 0; done_q 0; timeout counter 0.
REQ-034 Reset SHALL set last_grant = N_REQ-1, so requester 0 has first priority.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no sent or err pulse.
REQ-036 After reset release, the first arbitration SHALL occur on the first rising edge with any req high.

Verification
REQ-037 N_REQ=4, req=4'b0101, bytes 0xA5 (req 0) and 0x3C (req 2), transmitter model attached -> ack[0] first with din_tx=0xA5, sent[0]; then ack[2] with din_tx=0x3C, sent[2]; serial frames decode to 0xA5 then 0x3C.
REQ-038 req=4'b1111 held for 8 frames -> grant order 0,1,2,3,0,1,2,3; exactly one ack and one sent pulse per frame.
REQ-039 tx_line tied 1, TIMEOUT_CYC=16, req[1] pulse -> data_update high for exactly 16 cycles; err pulse; state IDLE; no sent pulse.
REQ-040 done_tx forced high before tx_line falls -> no sent pulse until done_tx goes 0 then 1.
REQ-041 rst_n low during WAIT_DONE -> all outputs reach reset values asynchronously; the next frame after release is granted to requester 0.
REQ-042 req[3] alone, byte 0xFF, with req_data changed to 0x00 mid-frame -> din_tx stays 0xFF until the sent pulse.
